rw_queue_sequencer: RTL and testbench
=====================================

Name: rw_queue_sequencer

Overview:
Per-register access-ordering queue, instantiated N_REGS times in the RF sequencer. It receives rw_queue_t entries ({id, rvalid, wready}) pushed by the dispatcher and raises full back to it. It grants execution-unit row reads and writes strictly in program order, one entry at a time, and exports a per-row scoreboard that the dispatcher uses for WAW detection.

Parameters:
DEPTH, 4, number of queued entries (power of 2, >=2)
N_ROWS, matrix_cps_pkg::N_ROWS, rows per matrix register
NUM_PORTS, 3, number of execution units with access ports

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
push_i  in  1  dispatcher push strobe
entry_i  in  rw_queue_t  pushed entry {id, rvalid, wready}
full_o  out  1  queue holds DEPTH entries
rd_req_i  in  NUM_PORTS  row-read request per unit
rd_id_i  in  NUM_PORTS x X_ID_WIDTH  instruction id of each read request
rd_row_i  in  NUM_PORTS x $clog2(N_ROWS)  requested row
rd_gnt_o  out  NUM_PORTS  read grant; req&gnt means the row read completes this cycle
wr_req_i  in  NUM_PORTS  row-write request per unit
wr_id_i  in  NUM_PORTS x X_ID_WIDTH  instruction id of each write request
wr_row_i  in  NUM_PORTS x $clog2(N_ROWS)  row being written
wr_gnt_o  out  NUM_PORTS  write grant; req&gnt means the row write commits this cycle
scoreboard_o  out  N_ROWS x rw_queue_t  per-row pending-access view
empty_o  out  1  no valid entries

Behaviour:
- Storage: circular buffer of DEPTH rw_queue_t entries with wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap) and count ($clog2(DEPTH+1) bits). The head is the entry at rd_ptr.
- Head progress: rd_done[N_ROWS] and wr_done[N_ROWS] flop vectors.
- Reset: pointers, count, rd_done and wr_done all 0. Outputs after reset: full_o=0, empty_o=1, all grants 0, scoreboard_o all 0.
- Push: accepted at the clock edge when push_i=1, full_o=0, and (entry_i.rvalid|entry_i.wready)=1. An entry with neither bit set is dropped. A push while full_o=1 is dropped even if a pop occurs in the same cycle; a simulation assertion fires.
- full_o = (count==DEPTH); empty_o = (count==0). Both are combinational from registered count.
- Read grant, combinational. Port p is eligible iff !empty, head.rvalid, rd_req_i[p], rd_id_i[p]==head.id and rd_done[rd_row_i[p]]==0. The lowest-index eligible port is granted; at most one read grant per cycle.
- Write grant, same rules using head.wready and wr_done. An entry with both rvalid and wready (read-modify-write) additionally requires rd_done[row]==1 for that row, or a same-row read granted in the same cycle. At most one write grant per cycle.
- Requests with a non-head id, or for an already-done row, get gnt=0 and must be held by the unit.
- On a granted access, the matching done bit is set at the clock edge.
- Retire: the head is complete when every row has rd_done (if rvalid) and wr_done (if wready), counting the grants issued this cycle. On completion, at that same edge: rd_ptr increments, count decrements, and rd_done and wr_done clear to 0. The next entry can be granted in the following cycle (0 idle cycles).
- Simultaneous push and retire: count is unchanged, and both pointers advance.
- scoreboard_o[r].id = head.id. For the head: scoreboard_o[r].rvalid = head.rvalid & !rd_done[r] and scoreboard_o[r].wready = head.wready & !wr_done[r]. Any non-head valid entry with wready forces scoreboard_o[r].wready=1 for all r. Scoreboard is all 0 when empty.
- Reset asserted mid-operation discards all entries and progress immediately (asynchronous). No grant is issued until the first push after reset release.
- Latency: push at edge k makes the entry grantable at cycle k+1 if it is the head.

Test Plan:
- Reset, then push {id=5, wready=1}; N_ROWS=4; unit1 writes rows 0..3 on consecutive cycles -> each wr_gnt_o[1]=1; scoreboard_o[r].wready drops after row r; empty_o=1 one cycle after the row-3 grant.
- Push {id=1, rvalid}, then {id=2, wready}; unit0 requests write id=2 first -> wr_gnt_o=0 until all 4 rows of id=1 are read; the write grant arrives in the cycle after the last read.
- RMW entry {id=3, rvalid=1, wready=1}: write of row 2 requested before read of row 2 -> no grant. Read row 2 and write row 2 in the same cycle -> both granted.
- Push 4 entries (DEPTH=4) -> full_o=1. Push a fifth while retiring the head -> fifth dropped, count=3, assertion fires. Continue until pointers wrap past 3 -> order preserved.
- Ports 0 and 2 both request read of row 1 for the head id -> only rd_gnt_o[0]=1. Port 2 retries row 1 -> gnt=0 (row done). Port 2 requests row 3 -> granted.
- Assert rst_ni low with 2 entries and row 1 half-done -> full_o=0, empty_o=1 and scoreboard_o=0 immediately; the next push with id=7 is granted from row 0.

Source files
------------

// File: rtl/rw_queue_sequencer.sv
// Per-register access-ordering queue: grants row reads/writes to execution units strictly
// in program order and exports a per-row pending-access scoreboard for WAW detection.
package matrix_cps_pkg;
  parameter int unsigned N_ROWS     = 4;
  parameter int unsigned X_ID_WIDTH = 8;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  rvalid;
    logic                  wready;
  } rw_queue_t;
endpackage

module rw_queue_sequencer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned N_ROWS    = matrix_cps_pkg::N_ROWS,
  parameter int unsigned NUM_PORTS = 3
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic                                                  push_i,
  input  matrix_cps_pkg::rw_queue_t                             entry_i,
  output logic                                                  full_o,
  input  logic [NUM_PORTS-1:0]                                  rd_req_i,
  input  logic [NUM_PORTS-1:0][matrix_cps_pkg::X_ID_WIDTH-1:0]  rd_id_i,
  input  logic [NUM_PORTS-1:0][$clog2(N_ROWS)-1:0]              rd_row_i,
  output logic [NUM_PORTS-1:0]                                  rd_gnt_o,
  input  logic [NUM_PORTS-1:0]                                  wr_req_i,
  input  logic [NUM_PORTS-1:0][matrix_cps_pkg::X_ID_WIDTH-1:0]  wr_id_i,
  input  logic [NUM_PORTS-1:0][$clog2(N_ROWS)-1:0]              wr_row_i,
  output logic [NUM_PORTS-1:0]                                  wr_gnt_o,
  output matrix_cps_pkg::rw_queue_t [N_ROWS-1:0]                scoreboard_o,
  output logic                                                  empty_o
);
  import matrix_cps_pkg::rw_queue_t;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ROW_W = $clog2(N_ROWS);

  rw_queue_t              mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [N_ROWS-1:0]      rd_done_q, wr_done_q;
  logic [N_ROWS-1:0]      rd_done_d, wr_done_d;
  rw_queue_t              head;
  logic                   empty, full, push_ok, retire;
  logic                   rd_fire, wr_fire, other_wr;
  logic [ROW_W-1:0]       rd_row, wr_row;

  assign head    = mem[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign full_o  = full;
  assign empty_o = empty;
  assign push_ok = push_i & ~full & (entry_i.rvalid | entry_i.wready);

  // Only the head entry may be granted; the lowest-index eligible port wins.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    rd_gnt_o = '0;
    rd_fire  = 1'b0;
    rd_row   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!rd_fire && !empty && head.rvalid && rd_req_i[p] &&
          rd_id_i[p] == head.id && !rd_done_q[rd_row_i[p]]) begin
        rd_gnt_o[p] = 1'b1;
        rd_fire     = 1'b1;
        rd_row      = rd_row_i[p];
      end
    end
  end

  // A read-modify-write entry may only write a row already read, or read this cycle.
  always_comb begin
    wr_gnt_o = '0;
    wr_fire  = 1'b0;
    wr_row   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!wr_fire && !empty && head.wready && wr_req_i[p] &&
          wr_id_i[p] == head.id && !wr_done_q[wr_row_i[p]] &&
          (!head.rvalid || rd_done_q[wr_row_i[p]] ||
           (rd_fire && rd_row == wr_row_i[p]))) begin
        wr_gnt_o[p] = 1'b1;
        wr_fire     = 1'b1;
        wr_row      = wr_row_i[p];
      end
    end
  end

  always_comb begin
    rd_done_d = rd_done_q;
    wr_done_d = wr_done_q;
    if (rd_fire) rd_done_d[rd_row] = 1'b1;
    if (wr_fire) wr_done_d[wr_row] = 1'b1;
    retire = !empty && (!head.rvalid || (&rd_done_d)) && (!head.wready || (&wr_done_d));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_done_q <= '0;
      wr_done_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (retire)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      rd_done_q <= retire ? '0 : rd_done_d;
      wr_done_q <= retire ? '0 : wr_done_d;
    end
  end

  // NOTE: entry storage has no reset; count_q alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= entry_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      push_when_full: assert (!(push_i && full && (entry_i.rvalid | entry_i.wready)))
        else $warning("rw_queue_sequencer: push while full was dropped");
    end
  end

  // Any queued writer behind the head keeps every row marked as write-pending.
  always_comb begin
    other_wr = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && mem[rd_ptr_q + PTR_W'(i)].wready) other_wr = 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < N_ROWS; r++) begin
      scoreboard_o[r] = '0;
      if (!empty) begin
        scoreboard_o[r].id     = head.id;
        scoreboard_o[r].rvalid = head.rvalid & ~rd_done_q[r];
        scoreboard_o[r].wready = (head.wready & ~wr_done_q[r]) | other_wr;
      end
    end
  end

endmodule

// File: tb/tb_rw_queue_sequencer.sv
// Directed bench for rw_queue_sequencer: grant expectations go through a queue and are
// popped when the combinational grants are sampled; registered state is checked mid-cycle.
module tb_rw_queue_sequencer;
  import matrix_cps_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned ROW_W     = $clog2(N_ROWS);

  logic                                   clk_i = 1'b0;
  logic                                   rst_ni;
  logic                                   push_i;
  rw_queue_t                              entry_i;
  logic                                   full_o, empty_o;
  logic [NUM_PORTS-1:0]                   rd_req_i, wr_req_i, rd_gnt_o, wr_gnt_o;
  logic [NUM_PORTS-1:0][X_ID_WIDTH-1:0]   rd_id_i, wr_id_i;
  logic [NUM_PORTS-1:0][ROW_W-1:0]        rd_row_i, wr_row_i;
  rw_queue_t [N_ROWS-1:0]                 scoreboard_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  rw_queue_sequencer #(.DEPTH(DEPTH), .N_ROWS(N_ROWS), .NUM_PORTS(NUM_PORTS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_i), .entry_i(entry_i), .full_o(full_o),
    .rd_req_i(rd_req_i), .rd_id_i(rd_id_i), .rd_row_i(rd_row_i), .rd_gnt_o(rd_gnt_o),
    .wr_req_i(wr_req_i), .wr_id_i(wr_id_i), .wr_row_i(wr_row_i), .wr_gnt_o(wr_gnt_o),
    .scoreboard_o(scoreboard_o), .empty_o(empty_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input logic [63:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  // Queue the expected grants for the stimulus just driven, then compare once settled.
  task automatic exp_gnt(input string tag, input logic [2:0] erd, input logic [2:0] ewr);
    exp_q.push_back('{tag: {tag, "_rd_gnt"}, val: 64'(erd)});
    exp_q.push_back('{tag: {tag, "_wr_gnt"}, val: 64'(ewr)});
    #1;
    pop_cmp(64'(rd_gnt_o));
    pop_cmp(64'(wr_gnt_o));
  endtask

  function automatic logic [63:0] sb_exp(input logic [X_ID_WIDTH-1:0] id,
                                         input logic [N_ROWS-1:0] rmask,
                                         input logic [N_ROWS-1:0] wmask);
    rw_queue_t [N_ROWS-1:0] s;
    for (int r = 0; r < N_ROWS; r++) s[r] = '{id: id, rvalid: rmask[r], wready: wmask[r]};
    return 64'(s);
  endfunction

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic clr_reqs();
    rd_req_i = '0;
    wr_req_i = '0;
  endtask

  task automatic set_rd(input int p, input logic [X_ID_WIDTH-1:0] id, input int row);
    rd_req_i[p] = 1'b1;
    rd_id_i[p]  = id;
    rd_row_i[p] = ROW_W'(row);
  endtask

  task automatic set_wr(input int p, input logic [X_ID_WIDTH-1:0] id, input int row);
    wr_req_i[p] = 1'b1;
    wr_id_i[p]  = id;
    wr_row_i[p] = ROW_W'(row);
  endtask

  task automatic do_push(input logic [X_ID_WIDTH-1:0] id, input logic rv, input logic wr);
    push_i  = 1'b1;
    entry_i = '{id: id, rvalid: rv, wready: wr};
    tick();
    push_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_ni   = 1'b0;
    push_i   = 1'b0;
    entry_i  = '0;
    rd_req_i = '0; rd_id_i = '0; rd_row_i = '0;
    wr_req_i = '0; wr_id_i = '0; wr_row_i = '0;
    tick(); tick();
    rst_ni = 1'b1;
    #1;
    check("reset_full",  64'(full_o),  64'd0);
    check("reset_empty", 64'(empty_o), 64'd1);
    check("reset_sb",    64'(scoreboard_o), 64'd0);
    exp_gnt("reset", 3'b000, 3'b000);
    tick();

    // Write-only entry, unit 1 writes every row once.
    do_push(8'd5, 1'b0, 1'b1);
    check("t1_empty", 64'(empty_o), 64'd0);
    check("t1_sb_init", 64'(scoreboard_o), sb_exp(8'd5, 4'b0000, 4'b1111));
    for (int r = 0; r < N_ROWS; r++) begin
      clr_reqs();
      set_wr(1, 8'd5, r);
      exp_gnt($sformatf("t1_row%0d", r), 3'b000, 3'b010);
      tick();
      if (r < N_ROWS - 1)
        check($sformatf("t1_sb_row%0d", r), 64'(scoreboard_o),
              sb_exp(8'd5, 4'b0000, 4'(4'b1111 << (r + 1))));
    end
    clr_reqs();
    check("t1_empty_after", 64'(empty_o), 64'd1);
    check("t1_sb_after", 64'(scoreboard_o), 64'd0);

    // Read-only entry ahead of a writer: write held until all reads retire the head.
    do_push(8'd1, 1'b1, 1'b0);
    do_push(8'd2, 1'b0, 1'b1);
    check("t2_sb_head", 64'(scoreboard_o), sb_exp(8'd1, 4'b1111, 4'b1111));
    set_wr(0, 8'd2, 0);
    exp_gnt("t2_wr_early", 3'b000, 3'b000);
    for (int r = 0; r < N_ROWS; r++) begin
      set_rd(0, 8'd1, r);
      exp_gnt($sformatf("t2_rd_row%0d", r), 3'b001, 3'b000);
      tick();
    end
    rd_req_i = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      set_wr(0, 8'd2, r);
      exp_gnt($sformatf("t2_wr_row%0d", r), 3'b000, 3'b001);
      tick();
    end
    clr_reqs();
    check("t2_empty", 64'(empty_o), 64'd1);

    // Read-modify-write entry: a row's write needs that row's read first or together.
    do_push(8'd3, 1'b1, 1'b1);
    set_wr(0, 8'd3, 2);
    exp_gnt("t3_wr_before_rd", 3'b000, 3'b000);
    tick();
    set_rd(1, 8'd3, 2);
    exp_gnt("t3_rmw_row2", 3'b010, 3'b001);
    tick();
    check("t3_sb_mid", 64'(scoreboard_o), sb_exp(8'd3, 4'b1011, 4'b1011));
    for (int r = 0; r < N_ROWS; r++) begin
      if (r != 2) begin
        set_rd(1, 8'd3, r);
        set_wr(0, 8'd3, r);
        exp_gnt($sformatf("t3_rmw_row%0d", r), 3'b010, 3'b001);
        tick();
      end
    end
    clr_reqs();
    check("t3_empty", 64'(empty_o), 64'd1);

    // Fill to DEPTH, then push while full in the head's retire cycle: push is dropped.
    for (int k = 0; k < DEPTH; k++) do_push(8'(10 + k), 1'b1, 1'b0);
    check("t4_full", 64'(full_o), 64'd1);
    for (int r = 0; r < N_ROWS; r++) begin
      set_rd(0, 8'd10, r);
      if (r == N_ROWS - 1) begin
        push_i  = 1'b1;
        entry_i = '{id: 8'd14, rvalid: 1'b1, wready: 1'b0};
      end
      exp_gnt($sformatf("t4_id10_row%0d", r), 3'b001, 3'b000);
      tick();
      push_i = 1'b0;
    end
    check("t4_full_after_drop", 64'(full_o), 64'd0);
    check("t4_not_empty", 64'(empty_o), 64'd0);
    for (int k = 1; k < DEPTH; k++) begin
      clr_reqs();
      check($sformatf("t4_head_id%0d", 10 + k), 64'(scoreboard_o),
            sb_exp(8'(10 + k), 4'b1111, 4'b0000));
      for (int r = 0; r < N_ROWS; r++) begin
        set_rd(0, 8'(10 + k), r);
        set_rd(2, 8'(11 + k), r);
        exp_gnt($sformatf("t4_id%0d_row%0d", 10 + k, r), 3'b001, 3'b000);
        tick();
      end
    end
    clr_reqs();
    check("t4_drained", 64'(empty_o), 64'd1);

    // Priority between ports and refusal of an already-read row.
    do_push(8'd20, 1'b1, 1'b0);
    set_rd(0, 8'd20, 1);
    set_rd(2, 8'd20, 1);
    exp_gnt("t5_both_row1", 3'b001, 3'b000);
    tick();
    rd_req_i[0] = 1'b0;
    exp_gnt("t5_retry_row1", 3'b000, 3'b000);
    tick();
    set_rd(2, 8'd20, 3);
    exp_gnt("t5_port2_row3", 3'b100, 3'b000);
    tick();
    clr_reqs();
    set_rd(0, 8'd20, 0);
    exp_gnt("t5_row0", 3'b001, 3'b000);
    tick();
    set_rd(0, 8'd20, 2);
    exp_gnt("t5_row2", 3'b001, 3'b000);
    tick();
    clr_reqs();
    check("t5_empty", 64'(empty_o), 64'd1);

    // Asynchronous reset mid-entry discards queue and progress.
    do_push(8'd30, 1'b1, 1'b0);
    do_push(8'd31, 1'b1, 1'b0);
    set_rd(0, 8'd30, 1);
    exp_gnt("t6_row1", 3'b001, 3'b000);
    tick();
    set_rd(0, 8'd30, 2);
    #1;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_full",  64'(full_o),  64'd0);
    check("t6_rst_empty", 64'(empty_o), 64'd1);
    check("t6_rst_sb",    64'(scoreboard_o), 64'd0);
    exp_gnt("t6_rst_gnt", 3'b000, 3'b000);
    tick();
    rst_ni = 1'b1;
    exp_gnt("t6_post_rst", 3'b000, 3'b000);
    clr_reqs();
    do_push(8'd7, 1'b0, 1'b1);
    for (int r = 0; r < N_ROWS; r++) begin
      set_wr(0, 8'd7, r);
      exp_gnt($sformatf("t6_id7_row%0d", r), 3'b000, 3'b001);
      tick();
    end
    clr_reqs();
    check("t6_empty", 64'(empty_o), 64'd1);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
